mcycle_sequencer: RTL and testbench

- Multi-cycle multiply/divide unit and sequencer for the RV32M extension in the single-cycle RV32I core.
- Sits beside the ALU and takes register-file operands Src_A/RD2. Its Stall output freezes the ProgramCounter and suppresses register write-back until the result is ready.
- Implements one shift-add multiplier and one restoring divider, each iterating one bit per cycle under a 3-state FSM.

---
 rtl/mcycle_sequencer.sv | 152 +++++++++++++++
 tb/tb_mcycle_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mcycle_sequencer.sv
// RV32M multi-cycle multiply/divide unit: one shift-add multiplier and one restoring divider.
// Each produces one bit per cycle. Stall freezes the core until the registered Result is valid.
module mcycle_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result,
    output logic             Busy,
    output logic             Done,
    output logic             Stall
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             r_state, w_next_state;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_opb;
    logic               r_neg_q, r_neg_r;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_quot, r_rem;

    logic             w_sign_a, w_sign_b, w_a_neg, w_b_neg;
    logic             w_div_zero, w_div_ovf, w_special, w_last;
    logic [WIDTH-1:0] w_a_mag, w_b_mag, w_special_res;

    // Operand signedness from funct3: only MULHU/DIVU/REMU treat rs1 as unsigned.
    assign w_sign_a   = ~(MCycleOp[0] & (MCycleOp[1] | MCycleOp[2]));
    assign w_sign_b   = w_sign_a & (MCycleOp != 3'b010);
    assign w_a_neg    = w_sign_a & Operand1[WIDTH-1];
    assign w_b_neg    = w_sign_b & Operand2[WIDTH-1];
    assign w_a_mag    = w_a_neg ? -Operand1 : Operand1;
    assign w_b_mag    = w_b_neg ? -Operand2 : Operand2;
    assign w_div_zero = MCycleOp[2] & (Operand2 == '0);
    assign w_div_ovf  = MCycleOp[2] & ~MCycleOp[0] & (Operand1 == MIN_NEG) & (&Operand2);
    assign w_special  = w_div_zero | w_div_ovf;
    assign w_special_res = MCycleOp[1] ? (w_div_zero ? Operand1 : '0)
                                       : (w_div_zero ? '1 : MIN_NEG);
    assign w_last     = (r_cnt == CNT_W'(WIDTH-1));

    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_prod_next, w_prod_fix;
    assign w_sum       = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_opb};
    assign w_prod_next = r_prod[0] ? {w_sum, r_prod[WIDTH-1:1]} : {1'b0, r_prod[2*WIDTH-1:1]};
    assign w_prod_fix  = r_neg_q ? -w_prod_next : w_prod_next;

    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH-1:0] w_diff, w_rem_next, w_quot_next;
    logic             w_ge;
    // The partial remainder is always below the divisor, so the low WIDTH bits of the difference are exact.
    assign w_rem_sh    = {r_rem, r_quot[WIDTH-1]};
    assign w_ge        = (w_rem_sh >= {1'b0, r_opb});
    assign w_diff      = w_rem_sh[WIDTH-1:0] - r_opb;
    assign w_rem_next  = w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
    assign w_quot_next = {r_quot[WIDTH-2:0], w_ge};

    logic [WIDTH-1:0] w_result;
    always_comb begin
        w_result = '0;
        case (r_op)
            3'b000:                 w_result = w_prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: w_result = w_prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         w_result = r_neg_q ? -w_quot_next : w_quot_next;
            default:                w_result = r_neg_r ? -w_rem_next : w_rem_next;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_next_state = r_state;
        Stall        = 1'b0;
        case (r_state)
            S_IDLE: begin
                Stall = Start;
                if (Start) w_next_state = w_special ? S_DONE : S_COMPUTE;
            end
            S_COMPUTE: begin
                Stall = 1'b1;
                if (w_last) w_next_state = S_DONE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_op    <= '0;
            r_opb   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_cnt   <= '0;
            r_prod  <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            Result  <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            Busy <= (w_next_state == S_COMPUTE);
            Done <= (w_next_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_op    <= MCycleOp;
                        r_opb   <= w_b_mag;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_cnt   <= '0;
                        if (w_special) begin
                            r_quot <= w_div_zero ? '1 : MIN_NEG;
                            r_rem  <= w_div_zero ? Operand1 : '0;
                            Result <= w_special_res;
                        end else if (MCycleOp[2]) begin
                            r_quot <= w_a_mag;
                            r_rem  <= '0;
                        end else begin
                            r_prod <= {{WIDTH{1'b0}}, w_a_mag};
                        end
                    end
                end
                S_COMPUTE: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_op[2]) begin
                        r_quot <= w_quot_next;
                        r_rem  <= w_rem_next;
                    end else begin
                        r_prod <= w_prod_next;
                    end
                    if (w_last) Result <= w_result;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mcycle_sequencer.sv
// Self-checking bench for mcycle_sequencer: directed RV32M cases, reset abort, back-to-back
// issue, and randomized operations checked against a 64-bit arithmetic reference model.
module tb_mcycle_sequencer;
    logic        clk = 1'b0;
    logic        reset, start;
    logic [2:0]  mop;
    logic [31:0] op1, op2, result;
    logic        busy, done, stall;

    int n_vec = 0;
    int n_err = 0;

    mcycle_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .CLK(clk), .Reset(reset), .Start(start), .MCycleOp(mop),
        .Operand1(op1), .Operand2(op2), .Result(result),
        .Busy(busy), .Done(done), .Stall(stall)
    );

    always #5 clk = ~clk;

    // RISC-V M-extension semantics using wide integer arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        int ia, ib;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        ia = $signed(a);
        ib = $signed(b);
        r  = '0;
        case (op)
            3'd0: begin p = sa * sb; r = p[31:0];  end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(ia / ib);
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(ia % ib);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int model_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return 33;
    endfunction

    // Issues one operation and measures it; Done is awaited for at most 60 cycles (lat=-1 on timeout).
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit hold,
                          output logic [31:0] res, output int lat, output int busy_n, output int stall_n,
                          output logic stall_t, output logic busy_t, output logic done_t, output logic stall_done);
        @(negedge clk);
        start = 1'b1; mop = op; op1 = a; op2 = b;
        #1;
        stall_t = stall; busy_t = busy; done_t = done;
        @(posedge clk);
        #1;
        if (!hold) begin
            start = 1'b0; mop = 3'($urandom); op1 = $urandom; op2 = $urandom;
        end
        lat = -1; busy_n = 0; stall_n = 0; res = 'x; stall_done = 1'bx;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k; res = result; stall_done = stall;
                break;
            end
            busy_n += int'(busy);
            stall_n += int'(stall);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; mop = '0; op1 = '0; op2 = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_vec += 4;
        if (busy !== 1'b0)    begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0)    begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        if (result !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h want 0", result); end
        if (stall !== 1'b0)   begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
    endtask

    task automatic test_directed();
        logic [2:0]  ops  [14] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6, 3'd4, 3'd0};
        logic [31:0] as   [14] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                   32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] bs   [14] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2,
                                   32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF};
        logic [31:0] exps [14] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                                   32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0, 32'h80000000, 32'd1};
        int          lats [14] = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1, 33, 33};
        logic [31:0] res;
        int lat, bn, sn;
        logic st, bt, dt, sd;
        for (int i = 0; i < 14; i++) begin
            run_op(ops[i], as[i], bs[i], 1'b0, res, lat, bn, sn, st, bt, dt, sd);
            n_vec += 5;
            if (res !== exps[i])   begin n_err++; $display("FAIL dir%0d_result: got %h want %h", i, res, exps[i]); end
            if (lat != lats[i])    begin n_err++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, lats[i]); end
            if (bn != lats[i] - 1) begin n_err++; $display("FAIL dir%0d_busy_cycles: got %0d want %0d", i, bn, lats[i] - 1); end
            if (st !== 1'b1)       begin n_err++; $display("FAIL dir%0d_stall_at_start: got %b want 1", i, st); end
            if (sd !== 1'b0)       begin n_err++; $display("FAIL dir%0d_stall_in_done: got %b want 0", i, sd); end
        end
    endtask

    task automatic test_abort();
        logic [31:0] res;
        int lat, bn, sn;
        logic st, bt, dt, sd;
        run_op(3'd5, 32'd5, 32'd0, 1'b0, res, lat, bn, sn, st, bt, dt, sd);
        n_vec++;
        if (res !== 32'hFFFFFFFF) begin n_err++; $display("FAIL abort_pre_result: got %h want ffffffff", res); end
        @(negedge clk);
        start = 1'b1; mop = 3'd0; op1 = 32'd7; op2 = 32'hFFFFFFFD;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_vec += 4;
        if (busy !== 1'b0)    begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
        if (done !== 1'b0)    begin n_err++; $display("FAIL abort_done: got %b want 0", done); end
        if (result !== 32'h0) begin n_err++; $display("FAIL abort_result: got %h want 0", result); end
        if (stall !== 1'b0)   begin n_err++; $display("FAIL abort_stall: got %b want 0", stall); end
        run_op(3'd0, 32'd3, 32'd4, 1'b0, res, lat, bn, sn, st, bt, dt, sd);
        n_vec += 2;
        if (res !== 32'd12) begin n_err++; $display("FAIL abort_fresh_result: got %h want 0000000c", res); end
        if (lat != 33)      begin n_err++; $display("FAIL abort_fresh_latency: got %0d want 33", lat); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int lat, bn, sn;
        logic st, bt, dt, sd;
        run_op(3'd0, 32'd7, 32'hFFFFFFFD, 1'b1, res, lat, bn, sn, st, bt, dt, sd);
        n_vec += 2;
        if (res !== 32'hFFFFFFEB) begin n_err++; $display("FAIL b2b_mul_result: got %h want ffffffeb", res); end
        if (lat != 33)            begin n_err++; $display("FAIL b2b_mul_latency: got %0d want 33", lat); end
        // Start stays high through DONE with the next instruction's operands.
        mop = 3'd4; op1 = 32'hFFFFFFF9; op2 = 32'd2;
        run_op(3'd4, 32'hFFFFFFF9, 32'd2, 1'b0, res, lat, bn, sn, st, bt, dt, sd);
        n_vec += 5;
        if (dt !== 1'b0)          begin n_err++; $display("FAIL b2b_done_width: got %b want 0", dt); end
        if (bt !== 1'b0)          begin n_err++; $display("FAIL b2b_start_in_done: busy got %b want 0", bt); end
        if (st !== 1'b1)          begin n_err++; $display("FAIL b2b_idle_stall: got %b want 1", st); end
        if (res !== 32'hFFFFFFFD) begin n_err++; $display("FAIL b2b_div_result: got %h want fffffffd", res); end
        if (lat != 33)            begin n_err++; $display("FAIL b2b_div_latency: got %0d want 33", lat); end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0) begin n_err++; $display("FAIL b2b_div_done_width: got %b want 0", done); end
    endtask

    task automatic test_random();
        logic [31:0] res, a, b, exp;
        logic [2:0] op;
        int lat, bn, sn, elat;
        logic st, bt, dt, sd;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
                default: ;
            endcase
            exp  = model(op, a, b);
            elat = model_latency(op, a, b);
            run_op(op, a, b, 1'b0, res, lat, bn, sn, st, bt, dt, sd);
            n_vec += 3;
            if (res !== exp)     begin n_err++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h: got %h want %h", i, op, a, b, res, exp); end
            if (lat != elat)     begin n_err++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, elat); end
            if (sn != elat - 1)  begin n_err++; $display("FAIL rnd%0d_stall_cycles: got %0d want %0d", i, sn, elat - 1); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_abort();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
